lcd_char_writer: RTL and testbench

- Physical-side driver for the Spartan-3E character LCD (HD44780-compatible, 4-bit mode, write-only).
- Sits between the CPU's `LCD` instruction datapath and the board pins.
- Performs the power-on init and configuration sequence autonomously.
- Then accepts one byte per valid/ready handshake (command or character) and serialises it as two timed nibble strobes.

---
 rtl/lcd_char_writer.sv | 229 ++++++++++++++++++++++
 tb/tb_lcd_char_writer.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_writer.sv
// rtl/lcd_char_writer.sv - HD44780 4-bit write-only driver: autonomous init/config, then one byte per handshake
module lcd_char_writer #(
  parameter int unsigned T_POWER = 750000,
  parameter int unsigned T_INIT1 = 205000,
  parameter int unsigned T_INIT2 = 5000,
  parameter int unsigned T_SHORT = 2000,
  parameter int unsigned T_CLEAR = 82000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_E     = 12,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_GAP   = 50
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iValid,
  output logic       oReady,
  output logic       oInitDone,
  output logic [3:0] oLCD_Data,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  localparam int unsigned MAX_T = max2(max2(max2(T_POWER, T_INIT1), max2(T_INIT2, T_SHORT)),
                                       max2(max2(T_CLEAR, T_SETUP), max2(max2(T_E, T_HOLD), T_GAP)));
  localparam int CW = $clog2(MAX_T + 1);

  // Terminal counts: a wait of N cycles runs the counter 0..N-1.
  localparam logic [CW-1:0] L_POWER = CW'(T_POWER - 1);
  localparam logic [CW-1:0] L_INIT1 = CW'(T_INIT1 - 1);
  localparam logic [CW-1:0] L_INIT2 = CW'(T_INIT2 - 1);
  localparam logic [CW-1:0] L_SHORT = CW'(T_SHORT - 1);
  localparam logic [CW-1:0] L_CLEAR = CW'(T_CLEAR - 1);
  localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] L_E     = CW'(T_E - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(T_GAP - 1);

  typedef enum logic [3:0] {
    POWER_WAIT, INIT_NIB, INIT_WAIT, CFG_LOAD, IDLE, HI_NIB, GAP, LO_NIB, BYTE_WAIT
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t        state_q, state_d;
  phase_t        ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    step_q, step_d;
  logic [7:0]    byte_q, byte_d;
  logic          brs_q, brs_d;
  logic          cfg_q, cfg_d;
  logic [3:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          e_q, e_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          nib_done;
  logic [CW-1:0] init_last, byte_last;
  logic [7:0]    cfg_val;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= POWER_WAIT;
      ph_q    <= PH_SETUP;
      cnt_q   <= '0;
      step_q  <= '0;
      byte_q  <= '0;
      brs_q   <= 1'b0;
      cfg_q   <= 1'b0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      byte_q  <= byte_d;
      brs_q   <= brs_d;
      cfg_q   <= cfg_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q + 1'b1;
    step_d   = step_q;
    byte_d   = byte_q;
    brs_d    = brs_q;
    cfg_d    = cfg_q;
    data_d   = data_q;
    rs_d     = rs_q;
    e_d      = 1'b0;
    ready_d  = 1'b0;
    done_d   = done_q;
    nib_done = 1'b0;
    cfg_val  = cfg_byte(step_q);

    init_last = (step_q == 2'd0) ? L_INIT1 : (step_q == 2'd1) ? L_INIT2 : L_SHORT;
    // Clear and Home need the long settle time; everything else is short.
    byte_last = (!brs_q && (byte_q == 8'h01 || byte_q == 8'h02)) ? L_CLEAR : L_SHORT;

    if (state_q inside {INIT_NIB, HI_NIB, LO_NIB}) begin
      case (ph_q)
        PH_SETUP: if (cnt_q == L_SETUP) begin
          ph_d  = PH_PULSE;
          cnt_d = '0;
          e_d   = 1'b1;
        end
        PH_PULSE: if (cnt_q == L_E) begin
          ph_d  = PH_HOLD;
          cnt_d = '0;
        end else begin
          e_d = 1'b1;
        end
        default: if (cnt_q == L_HOLD) nib_done = 1'b1;
      endcase
    end

    case (state_q)
      POWER_WAIT: if (cnt_q == L_POWER) begin
        state_d = INIT_NIB;
        ph_d    = PH_SETUP;
        cnt_d   = '0;
        step_d  = '0;
        data_d  = 4'h3;
        rs_d    = 1'b0;
      end
      INIT_NIB: if (nib_done) begin
        state_d = INIT_WAIT;
        cnt_d   = '0;
      end
      INIT_WAIT: if (cnt_q == init_last) begin
        cnt_d = '0;
        if (step_q == 2'd3) begin
          state_d = CFG_LOAD;
          step_d  = '0;
        end else begin
          state_d = INIT_NIB;
          ph_d    = PH_SETUP;
          step_d  = step_q + 2'd1;
          data_d  = (step_q == 2'd2) ? 4'h2 : 4'h3;
        end
      end
      CFG_LOAD: begin
        state_d = HI_NIB;
        ph_d    = PH_SETUP;
        cnt_d   = '0;
        byte_d  = cfg_val;
        brs_d   = 1'b0;
        cfg_d   = 1'b1;
        data_d  = cfg_val[7:4];
        rs_d    = 1'b0;
      end
      IDLE: begin
        cnt_d   = '0;
        done_d  = 1'b1;
        ready_d = 1'b1;
        if (iValid && ready_q) begin
          state_d = HI_NIB;
          ph_d    = PH_SETUP;
          byte_d  = iData;
          brs_d   = iRS;
          data_d  = iData[7:4];
          rs_d    = iRS;
          ready_d = 1'b0;
        end
      end
      HI_NIB: if (nib_done) begin
        state_d = GAP;
        cnt_d   = '0;
      end
      GAP: if (cnt_q == L_GAP) begin
        state_d = LO_NIB;
        ph_d    = PH_SETUP;
        cnt_d   = '0;
        data_d  = byte_q[3:0];
      end
      LO_NIB: if (nib_done) begin
        state_d = BYTE_WAIT;
        cnt_d   = '0;
      end
      BYTE_WAIT: if (cnt_q == byte_last) begin
        cnt_d = '0;
        if (!cfg_q) begin
          state_d = IDLE;
        end else if (step_q == 2'd3) begin
          state_d = IDLE;
          cfg_d   = 1'b0;
        end else begin
          state_d = CFG_LOAD;
          step_d  = step_q + 2'd1;
        end
      end
      default: state_d = POWER_WAIT;
    endcase
  end

  assign oReady    = ready_q;
  assign oInitDone = done_q;
  assign oLCD_Data = data_q;
  assign oLCD_E    = e_q;
  assign oLCD_RS   = rs_q;
  assign oLCD_RW   = 1'b0;

endmodule

// File: tb/tb_lcd_char_writer.sv
// tb/tb_lcd_char_writer.sv - randomized self-checking bench for lcd_char_writer against a nibble/timing model
module tb_lcd_char_writer;

  localparam int TPW = 20, TI1 = 10, TI2 = 6, TSH = 4, TCL = 8, TSU = 2, TE = 3, THO = 1, TGP = 2;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] iData;
  logic       iRS;
  logic       iValid;
  logic       oReady, oInitDone, oLCD_E, oLCD_RS, oLCD_RW;
  logic [3:0] oLCD_Data;

  int vectors = 0;
  int miscompares = 0;

  lcd_char_writer #(
    .T_POWER(TPW), .T_INIT1(TI1), .T_INIT2(TI2), .T_SHORT(TSH), .T_CLEAR(TCL),
    .T_SETUP(TSU), .T_E(TE), .T_HOLD(THO), .T_GAP(TGP)
  ) dut (
    .Clock(clk), .Reset(Reset), .iData(iData), .iRS(iRS), .iValid(iValid),
    .oReady(oReady), .oInitDone(oInitDone), .oLCD_Data(oLCD_Data),
    .oLCD_E(oLCD_E), .oLCD_RS(oLCD_RS), .oLCD_RW(oLCD_RW)
  );

  always #5 clk = ~clk;

  // Strobe recorder: one entry per completed E pulse.
  int         nib_q[$];
  int         rs_q[$];
  int         len_q[$];
  int         cyc = 0;
  int         last_e_cyc = 0;
  int         rw_bad = 0;
  int         chg_bad = 0;
  logic       prev_e = 1'b0;
  int         cur_len = 0;
  logic [3:0] cur_nib = '0;
  logic       cur_rs = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (oLCD_RW !== 1'b0) rw_bad = rw_bad + 1;
    if (oLCD_E === 1'b1) begin
      if (!prev_e) begin
        cur_len = 1;
        cur_nib = oLCD_Data;
        cur_rs  = oLCD_RS;
      end else begin
        cur_len = cur_len + 1;
        if (oLCD_Data !== cur_nib || oLCD_RS !== cur_rs) chg_bad = chg_bad + 1;
      end
      last_e_cyc = cyc;
    end else if (prev_e) begin
      nib_q.push_back(int'(cur_nib));
      rs_q.push_back(int'(cur_rs));
      len_q.push_back(cur_len);
    end
    prev_e = (oLCD_E === 1'b1);
  end

  function automatic int busy_model(input logic [7:0] d, input logic rs);
    int w;
    w = (!rs && (d == 8'h01 || d == 8'h02)) ? TCL : TSH;
    return 1 + 2 * (TSU + TE + THO) + TGP + w;
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec;
    nib_q.delete();
    rs_q.delete();
    len_q.delete();
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (oReady !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    ok = (oReady === 1'b1);
  endtask

  task automatic accept_byte(input logic [7:0] d, input logic rs, output int busy, output bit ok);
    wait_ready(ok);
    busy = 0;
    if (!ok) return;
    iData  = d;
    iRS    = rs;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    iData  = ~d;
    iRS    = ~rs;
    while (oReady !== 1'b1 && busy < 1000) begin
      busy++;
      tick();
    end
    ok = (busy < 1000);
  endtask

  task automatic check_byte_rec(input string name, input logic [7:0] d, input logic rs);
    vectors++;
    if (nib_q.size() != 2) begin
      miscompares++;
      $display("FAIL %s pulse count: got %0d want 2", name, nib_q.size());
      return;
    end
    vectors++;
    if (nib_q[0] != int'(d[7:4]) || nib_q[1] != int'(d[3:0]) || rs_q[0] != int'(rs) || rs_q[1] != int'(rs)) begin
      miscompares++;
      $display("FAIL %s nibbles: got %h/%h rs %0d/%0d want %h/%h rs %0d", name,
               nib_q[0], nib_q[1], rs_q[0], rs_q[1], d[7:4], d[3:0], rs);
    end
  endtask

  task automatic check_init_sequence(input string name);
    int exp_n[$];
    int cfg[4];
    int n;
    cfg = '{8'h28, 8'h06, 8'h0C, 8'h01};
    exp_n = '{3, 3, 3, 2};
    foreach (cfg[i]) begin
      exp_n.push_back(cfg[i] >> 4);
      exp_n.push_back(cfg[i] & 15);
    end
    clear_rec();
    iValid = 1'b0;
    Reset  = 1'b1;
    n = 0;
    while (oReady !== 1'b1 && oInitDone !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 5000) begin
      miscompares++;
      $display("FAIL %s init timeout: waited %0d cycles", name, n);
      return;
    end
    vectors++;
    if (oReady !== 1'b1 || oInitDone !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready/initdone together: ready=%b initdone=%b want 1/1", name, oReady, oInitDone);
    end
    vectors++;
    if (cyc - last_e_cyc != THO + TCL + 2) begin
      miscompares++;
      $display("FAIL %s clear tail: got %0d cycles want %0d", name, cyc - last_e_cyc, THO + TCL + 2);
    end
    vectors++;
    if (nib_q.size() != exp_n.size()) begin
      miscompares++;
      $display("FAIL %s init pulse count: got %0d want %0d", name, nib_q.size(), exp_n.size());
      return;
    end
    foreach (exp_n[i]) begin
      vectors++;
      if (nib_q[i] != exp_n[i] || rs_q[i] != 0 || len_q[i] != TE) begin
        miscompares++;
        $display("FAIL %s init pulse %0d: nib=%h rs=%0d len=%0d want nib=%h rs=0 len=%0d",
                 name, i, nib_q[i], rs_q[i], len_q[i], exp_n[i], TE);
      end
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    tick();
    tick();
    vectors++;
    if ({oLCD_Data, oLCD_E, oLCD_RS, oLCD_RW, oReady, oInitDone} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset outputs: data=%h e=%b rs=%b rw=%b ready=%b done=%b want all 0",
               oLCD_Data, oLCD_E, oLCD_RS, oLCD_RW, oReady, oInitDone);
    end
  endtask

  task automatic test_init;
    check_init_sequence("init");
  endtask

  task automatic test_single_byte;
    int busy;
    bit ok;
    clear_rec();
    accept_byte(8'h48, 1'b1, busy, ok);
    vectors++;
    if (!ok || busy != busy_model(8'h48, 1'b1)) begin
      miscompares++;
      $display("FAIL single busy: got %0d (ok=%0d) want %0d", busy, ok, busy_model(8'h48, 1'b1));
    end
    check_byte_rec("single", 8'h48, 1'b1);
    vectors++;
    if (len_q.size() == 2 && (len_q[0] != TE || len_q[1] != TE)) begin
      miscompares++;
      $display("FAIL single E width: got %0d/%0d want %0d", len_q[0], len_q[1], TE);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] str[4];
    int exp_n[$];
    bit ok;
    str = '{8'h48, 8'h6F, 8'h6C, 8'h61};
    foreach (str[i]) begin
      exp_n.push_back(int'(str[i][7:4]));
      exp_n.push_back(int'(str[i][3:0]));
    end
    clear_rec();
    wait_ready(ok);
    iRS    = 1'b1;
    iValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iData = str[i];
      tick();
      wait_ready(ok);
    end
    iValid = 1'b0;
    vectors++;
    if (!ok || nib_q.size() != exp_n.size()) begin
      miscompares++;
      $display("FAIL b2b pulse count: got %0d want %0d (ok=%0d)", nib_q.size(), exp_n.size(), ok);
      return;
    end
    foreach (exp_n[i]) begin
      vectors++;
      if (nib_q[i] != exp_n[i] || rs_q[i] != 1) begin
        miscompares++;
        $display("FAIL b2b nibble %0d: got %h rs=%0d want %h rs=1", i, nib_q[i], rs_q[i], exp_n[i]);
      end
    end
  endtask

  task automatic test_clear_home;
    logic [7:0] d_t[4];
    logic       r_t[4];
    int busy;
    bit ok;
    d_t = '{8'h01, 8'h02, 8'h01, 8'h03};
    r_t = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      clear_rec();
      accept_byte(d_t[i], r_t[i], busy, ok);
      vectors++;
      if (!ok || busy != busy_model(d_t[i], r_t[i])) begin
        miscompares++;
        $display("FAIL clear busy %h rs=%0d: got %0d want %0d", d_t[i], r_t[i], busy, busy_model(d_t[i], r_t[i]));
      end
      check_byte_rec("clear", d_t[i], r_t[i]);
    end
  endtask

  task automatic test_ignore_busy;
    int busy;
    bit ok;
    clear_rec();
    wait_ready(ok);
    iData  = 8'h3C;
    iRS    = 1'b1;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    busy = 0;
    while (oReady !== 1'b1 && busy < 1000) begin
      busy++;
      iData  = 8'hFF;
      iValid = (busy == 3 || busy == 8 || busy == 13);
      tick();
    end
    iValid = 1'b0;
    vectors++;
    if (busy != busy_model(8'h3C, 1'b1)) begin
      miscompares++;
      $display("FAIL ignore busy: got %0d want %0d", busy, busy_model(8'h3C, 1'b1));
    end
    check_byte_rec("ignore", 8'h3C, 1'b1);
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic       rs;
    int busy;
    bit ok;
    for (int k = 0; k < 16; k++) begin
      d  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 2));
      rs = 1'($urandom_range(0, 1));
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      clear_rec();
      accept_byte(d, rs, busy, ok);
      vectors++;
      if (!ok || busy != busy_model(d, rs)) begin
        miscompares++;
        $display("FAIL random busy %h rs=%0d: got %0d want %0d", d, rs, busy, busy_model(d, rs));
      end
      check_byte_rec("random", d, rs);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n;
    clear_rec();
    wait_ready(ok);
    iData  = 8'h5A;
    iRS    = 1'b1;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    n = 0;
    while (!(nib_q.size() == 1 && oLCD_E === 1'b1) && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL midreset never reached low-nibble pulse");
    end
    Reset = 1'b0;
    #1;
    vectors++;
    if (oLCD_E !== 1'b0 || oReady !== 1'b0 || oInitDone !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset async: e=%b ready=%b done=%b want 0/0/0", oLCD_E, oReady, oInitDone);
    end
    tick();
    tick();
    check_init_sequence("reinit");
  endtask

  task automatic test_static_rules;
    vectors++;
    if (rw_bad != 0) begin
      miscompares++;
      $display("FAIL rw high samples: got %0d want 0", rw_bad);
    end
    vectors++;
    if (chg_bad != 0) begin
      miscompares++;
      $display("FAIL data change under E: got %0d want 0", chg_bad);
    end
  endtask

  initial begin
    Reset  = 1'b0;
    iValid = 1'b0;
    iData  = '0;
    iRS    = 1'b0;
    test_reset();
    test_init();
    test_single_byte();
    test_back_to_back();
    test_clear_home();
    test_ignore_busy();
    test_random();
    test_reset_mid();
    test_static_rules();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
